key_filter_led: RTL and testbench
=================================

// Module: key_filter_led
// PURPOSE
//   Cleans a raw board push-button for the key/LED path: 2-FF synchroniser, counter-based
//   debounce FSM, one-cycle press/release strobes, and an LED that toggles on each confirmed
//   press. Sits between the board key pin and registered LED logic, supplying a clean key
//   instead of the raw bouncing pin.
// PARAMETERS
//   CNT_MAX        999_999  debounce count; 20 ms at 50 MHz. Benches use 4.
//   KEY_ACTIVE_LOW 1        1: key_in=0 means pressed; 0: key_in=1 means pressed.
// PORTS
//   sys_clk     in   1  single system clock, all logic on rising edge
//   sys_rst     in   1  asynchronous, active-high reset
//   key_in      in   1  raw asynchronous key pin
//   key_state   out  1  debounced level, 1 = pressed
//   press_flag  out  1  1-cycle strobe on a confirmed press
//   rel_flag    out  1  1-cycle strobe on a confirmed release
//   led_out     out  1  toggles on every press_flag
// BEHAVIOUR
//   - Reset (async, immediate, including mid-filter): state=IDLE, cnt=0, key_state=0,
//     press_flag=0, rel_flag=0, led_out=0. Both sync FFs load the released level
//     (1 if KEY_ACTIVE_LOW, else 0), so no spurious press after reset.
//   - Sync: key_in -> s1 -> s2. press_s = KEY_ACTIVE_LOW ? ~s2 : s2.
//   - cnt width = $clog2(CNT_MAX+1). It never exceeds CNT_MAX and never wraps.
//   - FSM, evaluated every cycle:
//       IDLE:   press_s=1 -> P_FILT, cnt<=0. Otherwise stay.
//       P_FILT: press_s=0 -> IDLE, cnt<=0 (bounce rejected).
//               cnt==CNT_MAX -> DOWN, key_state<=1, press_flag<=1, led_out<=~led_out.
//               Otherwise cnt<=cnt+1.
//       DOWN:   press_s=0 -> R_FILT, cnt<=0. Otherwise stay.
//       R_FILT: press_s=1 -> DOWN, cnt<=0 (bounce rejected, no flags).
//               cnt==CNT_MAX -> IDLE, key_state<=0, rel_flag<=1.
//               Otherwise cnt<=cnt+1.
//   - Acceptance: press_s must be sampled at the new level for CNT_MAX+2 consecutive cycles,
//     counted from the first sample after the sync stage.
//   - press_flag, key_state and led_out update on the same edge.
//   - Latency from a clean key_in edge to the flag: CNT_MAX+4 cycles
//     (2 sync cycles + CNT_MAX+2 filter cycles).
//   - Flags are registered, high exactly one cycle, default 0 every other cycle.
//     press_flag and rel_flag are never high together.
//   - Any single-cycle opposite sample inside a filter state restarts filtering from scratch.
//   - key_state changes only on flag cycles. led_out changes only on press_flag cycles.
// TESTING (CNT_MAX=4, KEY_ACTIVE_LOW=1, 10 ns clock)
//   1 Reset: assert sys_rst with key_in=1, release it, hold key_in=1 for 50 cycles ->
//     all outputs stay 0.
//   2 Clean press: key_in 1->0 and hold -> press_flag high for 1 cycle exactly 8 cycles
//     after the edge; key_state=1 and led_out=1 on that same cycle.
//   3 Bounce: key_in=0 for 3 cycles, 1 for 1 cycle, then 0 and held -> no flag during the
//     bounce; press_flag 8 cycles after the final 1->0 edge; exactly one strobe.
//   4 Release: from DOWN, key_in 0->1 and hold -> rel_flag pulse 8 cycles later;
//     key_state=0; led_out unchanged.
//   5 Toggle count: 3 clean press/release pairs -> 3 press_flags, 3 rel_flags,
//     led_out sequence 1,0,1.
//   6 Reset mid-filter: assert sys_rst asynchronously (off-edge) while in P_FILT with cnt=2
//     -> outputs clear immediately; after release with key_in still 0, press_flag arrives
//     CNT_MAX+4 cycles later.

Source files
------------

// File: rtl/key_filter_led_if.sv
// Key/LED signal bundle between the board-side driver and the key filter.
//   key_in     raw asynchronous key pin (driven by master)
//   key_state  debounced level, 1 = pressed
//   press_flag one-cycle strobe on a confirmed press
//   rel_flag   one-cycle strobe on a confirmed release
//   led_out    LED level, toggles on every press_flag
// Strobe semantics: press_flag and rel_flag are registered and high for
// exactly one sys_clk cycle. They are never high together. There is no
// back-pressure, so the consumer must sample them on every rising edge.
interface key_filter_led_if;
  logic key_in;
  logic key_state;
  logic press_flag;
  logic rel_flag;
  logic led_out;

  modport master (
    output key_in,
    input  key_state,
    input  press_flag,
    input  rel_flag,
    input  led_out
  );

  modport slave (
    input  key_in,
    output key_state,
    output press_flag,
    output rel_flag,
    output led_out
  );
endinterface

// File: rtl/key_filter_led.sv
// Push-button cleaner: 2-FF synchroniser, counter-based debounce FSM,
// one-cycle press/release strobes and an LED that toggles on every press.
// Ports:
//   sys_clk    single system clock, rising edge
//   sys_rst    asynchronous active-high reset
//   key        key_filter_led_if.slave (key_in in, key_state/flags/led out)
//   dbg_state  current debounce FSM state, for observation only
// A new level is accepted once the synchronised key has been sampled at
// that level for CNT_MAX+2 consecutive cycles. The first sample moves the
// FSM into a filter state, and the next CNT_MAX+1 samples count cnt from
// 0 up to CNT_MAX. Any opposite sample drops back and restarts the count.
module key_filter_led #(
  parameter int CNT_MAX        = 999_999,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  key_filter_led_if.slave  key,
  output logic [1:0]       dbg_state
);

  localparam int   CW      = $clog2(CNT_MAX + 1);
  localparam logic REL_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_FILT = 2'd1,
    DOWN   = 2'd2,
    R_FILT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s1;
  logic          s2;
  logic          press_s;

  // Both synchroniser stages reset to the released level. Otherwise the
  // first cycles after reset could look like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= key.key_in;
      s2 <= s1;
    end
  end

  // Normalise polarity so the FSM always sees 1 = pressed.
  assign press_s = KEY_ACTIVE_LOW ? ~s2 : s2;

  // Debounce FSM with registered outputs. The flags default to 0 every
  // cycle and are raised only on the acceptance edge. This makes them
  // exactly one cycle wide.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      key.key_state  <= 1'b0;
      key.press_flag <= 1'b0;
      key.rel_flag   <= 1'b0;
      key.led_out    <= 1'b0;
    end else begin
      key.press_flag <= 1'b0;
      key.rel_flag   <= 1'b0;
      case (state)
        IDLE: begin
          if (press_s) begin
            state <= P_FILT;
            cnt   <= '0;
          end
        end
        P_FILT: begin
          if (!press_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_TOP) begin
            // cnt holds at CNT_MAX here and is cleared on the next filter entry.
            state          <= DOWN;
            key.key_state  <= 1'b1;
            key.press_flag <= 1'b1;
            key.led_out    <= ~key.led_out;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!press_s) begin
            state <= R_FILT;
            cnt   <= '0;
          end
        end
        R_FILT: begin
          if (press_s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_TOP) begin
            state         <= IDLE;
            key.key_state <= 1'b0;
            key.rel_flag  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_key_filter_led.sv
module tb_key_filter_led;
  localparam int CNT_MAX = 4;
  localparam int LAT     = CNT_MAX + 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] dbg_state;

  key_filter_led_if kif ();

  key_filter_led #(.CNT_MAX(CNT_MAX), .KEY_ACTIVE_LOW(1'b1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key       (kif.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Model rule: delay the pin by two register stages. Count the consecutive
  // samples in which the synchronised "pressed" level differs from the
  // debounced level. When that count reaches CNT_MAX+2, the new level is
  // accepted and the matching strobe is raised.
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_key = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_led = 1'b0;
  int   m_run = 0;
  logic [0:0] exp_q[$];   // expected led_out value for each press strobe

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0;
      m_key = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_led = 1'b0;
    end else begin
      m_press = 1'b0;
      m_rel   = 1'b0;
      if ((!m_s2) != m_key) begin
        m_run++;
        if (m_run == CNT_MAX + 2) begin
          m_run = 0;
          m_key = !m_key;
          if (m_key) begin
            m_press = 1'b1;
            m_led   = !m_led;
            exp_q.push_back(m_led);
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = kif.key_in;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      n_checks++;
      if ({kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out} !==
          {m_key, m_press, m_rel, m_led})
        $display("FAIL model_cmp t=%0t dut ks/pf/rf/led=%b%b%b%b model=%b%b%b%b",
                 $time, kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out,
                 m_key, m_press, m_rel, m_led);
      else n_pass++;
      if (kif.press_flag === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL sb_unexpected_press t=%0t got led=%b required no strobe", $time, kif.led_out);
        else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          if (kif.led_out !== e)
            $display("FAIL sb_led t=%0t got %b required %b", $time, kif.led_out, e);
          else n_pass++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    kif.key_in = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    kif.key_in = 1'b1;
    sys_rst    = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_checks++;
      if ({kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out} !== 4'b0000)
        $display("FAIL reset_idle cycle=%0d got %b%b%b%b required 0000", k,
                 kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int flags = 0;
    kif.key_in = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (kif.press_flag === 1'b1) flags++;
      n_checks++;
      if (kif.press_flag !== (k == LAT))
        $display("FAIL press_latency cycle=%0d got %b required %b", k, kif.press_flag, k == LAT);
      else n_pass++;
      if (k == LAT) begin
        n_checks++;
        if ({kif.key_state, kif.led_out} !== 2'b11)
          $display("FAIL press_outputs got ks=%b led=%b required ks=1 led=1", kif.key_state, kif.led_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (flags != 1) $display("FAIL press_count got %0d required 1", flags);
    else n_pass++;
  endtask

  task automatic test_release();
    logic led_before;
    led_before = kif.led_out;
    kif.key_in = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      n_checks++;
      if (kif.rel_flag !== (k == LAT))
        $display("FAIL rel_latency cycle=%0d got %b required %b", k, kif.rel_flag, k == LAT);
      else n_pass++;
    end
    n_checks++;
    if ({kif.key_state, kif.led_out} !== {1'b0, led_before})
      $display("FAIL rel_outputs got ks=%b led=%b required ks=0 led=%b",
               kif.key_state, kif.led_out, led_before);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int flags = 0;
    kif.key_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) kif.key_in = 1'b1;
      tick();
      if (kif.press_flag === 1'b1) flags++;
    end
    kif.key_in = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (kif.press_flag === 1'b1) flags++;
      n_checks++;
      if (kif.press_flag !== (k == LAT))
        $display("FAIL bounce_latency cycle=%0d got %b required %b", k, kif.press_flag, k == LAT);
      else n_pass++;
    end
    n_checks++;
    if (flags != 1) $display("FAIL bounce_count got %0d required 1", flags);
    else n_pass++;
  endtask

  task automatic test_toggle_count();
    logic [2:0] led_seq = 3'b101;  // led after press 0,1,2 -> 1,0,1
    int np = 0, nr = 0;
    for (int p = 0; p < 3; p++) begin
      kif.key_in = 1'b0;
      for (int k = 1; k <= LAT + 3; k++) begin
        tick();
        if (kif.press_flag === 1'b1) begin
          np++;
          n_checks++;
          if (kif.led_out !== led_seq[2-p])
            $display("FAIL toggle_led press=%0d got %b required %b", p, kif.led_out, led_seq[2-p]);
          else n_pass++;
        end
      end
      kif.key_in = 1'b1;
      for (int k = 1; k <= LAT + 3; k++) begin
        tick();
        if (kif.rel_flag === 1'b1) nr++;
      end
    end
    n_checks++;
    if (np != 3 || nr != 3)
      $display("FAIL toggle_counts got press=%0d rel=%0d required 3/3", np, nr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_filter();
    kif.key_in = 1'b0;
    for (int k = 0; k < 5; k++) tick();   // P_FILT entered at edge 3, cnt=2 after edge 5
    #2 sys_rst = 1'b1;                     // off-edge assertion
    #1;
    n_checks++;
    if ({kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out} !== 4'b0000)
      $display("FAIL midreset_clear got %b%b%b%b required 0000",
               kif.key_state, kif.press_flag, kif.rel_flag, kif.led_out);
    else n_pass++;
    sys_rst = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      n_checks++;
      if (kif.press_flag !== (k == LAT))
        $display("FAIL midreset_latency cycle=%0d got %b required %b", k, kif.press_flag, k == LAT);
      else n_pass++;
    end
    hold(1'b1, LAT + 4);
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++)
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    hold(1'b1, LAT + 6);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_missing_press got %0d pending required 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    kif.key_in = 1'b1;
    test_reset();
    test_clean_press();
    hold(1'b0, 5);
    test_release();
    hold(1'b1, 5);
    test_bounce();
    hold(1'b0, 3);
    test_release();
    hold(1'b1, 5);
    test_toggle_count();
    test_reset_mid_filter();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
